// File: rtl/coin_pkg.sv
// Shared constants and state encoding for the coin dispenser.
// Denomination values are indexed by their eject bit position.
package coin_pkg;

    localparam int unsigned N_DENOM = 6;
    localparam int unsigned AMT_W   = 16;

    // Index i holds the cent value driven on eject bit i (bit0=1c ... bit5=500c).
    localparam logic [AMT_W-1:0] DENOM_VAL [N_DENOM] = '{
        16'd1, 16'd5, 16'd10, 16'd25, 16'd100, 16'd500
    };

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_EJECT,
        S_GAP,
        S_DONE
    } state_t;

endpackage

// File: rtl/coin_dispenser_if.sv
// Request/response bundle between the vending controller and the coin dispenser.
interface coin_dispenser_if;
    import coin_pkg::*;

    logic               I_START;
    logic [AMT_W-1:0]   I_AMOUNT;
    logic               I_REFILL;
    logic [N_DENOM-1:0] O_COIN_EJECT;
    logic               O_BUSY;
    logic               O_DONE;
    logic               O_SHORT;
    logic [AMT_W-1:0]   O_REMAINDER;

    modport master (
        output I_START, I_AMOUNT, I_REFILL,
        input  O_COIN_EJECT, O_BUSY, O_DONE, O_SHORT, O_REMAINDER
    );

    modport slave (
        input  I_START, I_AMOUNT, I_REFILL,
        output O_COIN_EJECT, O_BUSY, O_DONE, O_SHORT, O_REMAINDER
    );

endinterface

// File: rtl/coin_select.sv
// Greedy pick: largest in-stock denomination not exceeding the remaining amount.
module coin_select
    import coin_pkg::*;
(
    input  logic [AMT_W-1:0]   remaining,
    input  logic [N_DENOM-1:0] avail,
    output logic               valid_c,
    output logic [N_DENOM-1:0] onehot_c,
    output logic [AMT_W-1:0]   value_c
);

    // Ascending scan; the last hit is the largest eligible coin.
    always_comb begin
        valid_c  = 1'b0;
        onehot_c = '0;
        value_c  = '0;
        for (int i = 0; i < N_DENOM; i++) begin
            if (avail[i] && (DENOM_VAL[i] <= remaining)) begin
                valid_c  = 1'b1;
                onehot_c = N_DENOM'(1) << i;
                value_c  = DENOM_VAL[i];
            end
        end
    end

endmodule

// File: rtl/coin_dispenser.sv
// Change-return engine: greedy coin breakdown, one solenoid pulse at a time,
// per-denomination inventory with refill and shortfall reporting.
module coin_dispenser
    import coin_pkg::*;
#(
    parameter int unsigned INV_WIDTH    = 8,
    parameter int unsigned INIT_COUNT   = 20,
    parameter int unsigned EJECT_CYCLES = 2
) (
    input  logic            I_CLK,
    input  logic            I_RESET,
    coin_dispenser_if.slave bus
);

    localparam int unsigned CNT_W = 4;

    state_t               state_q, state_d;
    logic [AMT_W-1:0]     remaining_q, remaining_d;
    logic [INV_WIDTH-1:0] inv [N_DENOM];
    logic [INV_WIDTH-1:0] inv_d [N_DENOM];
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [N_DENOM-1:0]   eject_q, eject_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 short_q, short_d;
    logic [AMT_W-1:0]     rem_q, rem_d;

    logic [N_DENOM-1:0]   avail;
    logic                 sel_valid;
    logic [N_DENOM-1:0]   sel_onehot;
    logic [AMT_W-1:0]     sel_value;

    always_comb begin
        avail = '0;
        for (int i = 0; i < N_DENOM; i++) begin
            avail[i] = (inv[i] != '0);
        end
    end

    coin_select u_select (
        .remaining (remaining_q),
        .avail     (avail),
        .valid_c   (sel_valid),
        .onehot_c  (sel_onehot),
        .value_c   (sel_value)
    );

    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            cnt_q       <= '0;
            eject_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            short_q     <= 1'b0;
            rem_q       <= '0;
            for (int i = 0; i < N_DENOM; i++) begin
                inv[i] <= INV_WIDTH'(INIT_COUNT);
            end
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            cnt_q       <= cnt_d;
            eject_q     <= eject_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            short_q     <= short_d;
            rem_q       <= rem_d;
            for (int i = 0; i < N_DENOM; i++) begin
                inv[i] <= inv_d[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        cnt_d       = cnt_q;
        eject_d     = eject_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        short_d     = short_q;
        rem_d       = rem_q;
        for (int i = 0; i < N_DENOM; i++) begin
            inv_d[i] = inv[i];
        end

        case (state_q)
            S_IDLE: begin
                // A refill coinciding with a start lands first, so the start sees full stock.
                if (bus.I_REFILL) begin
                    for (int i = 0; i < N_DENOM; i++) begin
                        inv_d[i] = INV_WIDTH'(INIT_COUNT);
                    end
                end
                if (bus.I_START) begin
                    remaining_d = bus.I_AMOUNT;
                    short_d     = 1'b0;
                    rem_d       = '0;
                    busy_d      = 1'b1;
                    state_d     = S_SELECT;
                end
            end
            S_SELECT: begin
                if (sel_valid) begin
                    remaining_d = remaining_q - sel_value;
                    for (int i = 0; i < N_DENOM; i++) begin
                        if (sel_onehot[i]) begin
                            inv_d[i] = inv[i] - INV_WIDTH'(1);
                        end
                    end
                    cnt_d   = CNT_W'(EJECT_CYCLES);
                    eject_d = sel_onehot;
                    state_d = S_EJECT;
                end else begin
                    done_d  = 1'b1;
                    short_d = (remaining_q != '0);
                    rem_d   = remaining_q;
                    state_d = S_DONE;
                end
            end
            S_EJECT: begin
                if (cnt_q == CNT_W'(1)) begin
                    eject_d = '0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_GAP: begin
                state_d = S_SELECT;
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.O_COIN_EJECT = eject_q;
    assign bus.O_BUSY       = busy_q;
    assign bus.O_DONE       = done_q;
    assign bus.O_SHORT      = short_q;
    assign bus.O_REMAINDER  = rem_q;

endmodule

// File: tb/tb_coin_dispenser.sv
// Scoreboard bench for coin_dispenser: two instances (INIT_COUNT 20 and 2)
// share stimulus; expected ejects and DONE results are queued, a monitor checks them.
module tb_coin_dispenser;
    import coin_pkg::*;

    localparam int unsigned EJ = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        refill = 1'b0;
    logic        sel = 1'b0;
    logic [15:0] amount = '0;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    coin_dispenser_if bus_a ();
    coin_dispenser_if bus_b ();

    assign bus_a.I_START  = start & ~sel;
    assign bus_a.I_REFILL = refill & ~sel;
    assign bus_a.I_AMOUNT = amount;
    assign bus_b.I_START  = start & sel;
    assign bus_b.I_REFILL = refill & sel;
    assign bus_b.I_AMOUNT = amount;

    coin_dispenser #(.INV_WIDTH(8), .INIT_COUNT(20), .EJECT_CYCLES(EJ)) u_dut (
        .I_CLK(clk), .I_RESET(rst), .bus(bus_a)
    );
    coin_dispenser #(.INV_WIDTH(8), .INIT_COUNT(2), .EJECT_CYCLES(EJ)) u_dut2 (
        .I_CLK(clk), .I_RESET(rst), .bus(bus_b)
    );

    logic [5:0]  m_ej;
    logic        m_busy, m_done, m_short;
    logic [15:0] m_rem;
    assign m_ej    = sel ? bus_b.O_COIN_EJECT : bus_a.O_COIN_EJECT;
    assign m_busy  = sel ? bus_b.O_BUSY       : bus_a.O_BUSY;
    assign m_done  = sel ? bus_b.O_DONE       : bus_a.O_DONE;
    assign m_short = sel ? bus_b.O_SHORT      : bus_a.O_SHORT;
    assign m_rem   = sel ? bus_b.O_REMAINDER  : bus_a.O_REMAINDER;

    typedef struct {
        bit          is_done;
        logic [5:0]  coin;
        bit          shrt;
        logic [15:0] rem;
        int          dcyc;
    } ev_t;

    ev_t        sbq[$];
    logic [5:0] exp_coins[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: checks every eject pulse and DONE against the scoreboard queue.
    logic [5:0] prev_ej = '0;
    int         run = 0;
    always @(negedge clk) begin
        ev_t e;
        if (rst) begin
            prev_ej = '0;
            run     = 0;
        end else begin
            if (prev_ej != '0 && m_ej != prev_ej) begin
                chk("eject_width", 64'(run), 64'(EJ));
                chk("eject_gap", 64'(m_ej), 64'(0));
            end
            if (m_ej != '0 && m_ej != prev_ej) begin
                run = 1;
                if (sbq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_eject: got %b expected none", m_ej);
                end else begin
                    e = sbq.pop_front();
                    chk("eject_kind", 64'(e.is_done), 64'(0));
                    chk("eject_coin", 64'(m_ej), 64'(e.coin));
                end
            end else if (m_ej != '0) begin
                run++;
            end
            if (m_done) begin
                if (sbq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_done: got done=1 expected none");
                end else begin
                    e = sbq.pop_front();
                    chk("done_kind", 64'(e.is_done), 64'(1));
                    chk("done_short", 64'(m_short), 64'(e.shrt));
                    chk("done_remainder", 64'(m_rem), 64'(e.rem));
                    chk("done_cycle", 64'(cyc), 64'(e.dcyc));
                    chk("done_busy", 64'(m_busy), 64'(1));
                    chk("done_no_eject", 64'(m_ej), 64'(0));
                end
            end
            prev_ej = m_ej;
        end
    end

    task automatic wait_done();
        bit got = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (m_done) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            n_cmp++; n_bad++;
            $display("FAIL done_timeout: got no done expected done");
        end
        @(negedge clk);
    endtask

    task automatic wait_eject(input int bitn);
        bit got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (m_ej[bitn]) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            n_cmp++; n_bad++;
            $display("FAIL eject_timeout: got no eject expected bit %0d", bitn);
        end
    endtask

    // Queues exp_coins plus a DONE event, issues the start, optionally
    // pokes a second start mid-eject, then waits for DONE.
    task automatic txn(input bit which, input logic [15:0] amt, input bit rf,
                       input bit exp_short, input logic [15:0] exp_rem, input bit intr);
        ev_t e;
        int  n;
        @(negedge clk);
        sel = which;
        n = exp_coins.size();
        foreach (exp_coins[i]) begin
            e = '{is_done: 1'b0, coin: exp_coins[i], shrt: 1'b0, rem: '0, dcyc: 0};
            sbq.push_back(e);
        end
        exp_coins.delete();
        e = '{is_done: 1'b1, coin: '0, shrt: exp_short, rem: exp_rem, dcyc: cyc + 2 + 4 * n};
        sbq.push_back(e);
        start  = 1'b1;
        amount = amt;
        refill = rf;
        @(negedge clk);
        start  = 1'b0;
        refill = 1'b0;
        if (intr) begin
            wait_eject(4);
            start  = 1'b1;
            amount = 16'd500;
            @(negedge clk);
            start  = 1'b0;
        end
        wait_done();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_eject", 64'(bus_a.O_COIN_EJECT), 64'(0));
        chk("reset_busy", 64'(bus_a.O_BUSY), 64'(0));
        chk("reset_done", 64'(bus_a.O_DONE), 64'(0));
        chk("reset_short", 64'(bus_a.O_SHORT), 64'(0));
        chk("reset_remainder", 64'(bus_a.O_REMAINDER), 64'(0));
        chk("reset_inv_1c", 64'(u_dut.inv[0]), 64'(20));

        // Zero amount: straight to DONE two cycles after acceptance.
        txn(1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 1'b0);

        // 130 = 100 + 25 + 5
        exp_coins = '{6'b010000, 6'b001000, 6'b000010};
        txn(1'b0, 16'd130, 1'b0, 1'b0, 16'd0, 1'b0);
        chk("inv_100_after_130", 64'(u_dut.inv[4]), 64'(19));
        chk("inv_25_after_130", 64'(u_dut.inv[3]), 64'(19));
        chk("inv_5_after_130", 64'(u_dut.inv[1]), 64'(19));
        chk("inv_500_after_130", 64'(u_dut.inv[5]), 64'(20));

        // Second start during eject must be ignored.
        exp_coins = '{6'b010000, 6'b001000, 6'b000010};
        txn(1'b0, 16'd130, 1'b0, 1'b0, 16'd0, 1'b1);
        repeat (10) @(negedge clk);

        // Drain all twenty 1c coins, four at a time.
        for (int k = 0; k < 5; k++) begin
            exp_coins = '{6'b000001, 6'b000001, 6'b000001, 6'b000001};
            txn(1'b0, 16'd4, 1'b0, 1'b0, 16'd0, 1'b0);
        end
        txn(1'b0, 16'd3, 1'b0, 1'b1, 16'd3, 1'b0);
        repeat (3) @(negedge clk);
        chk("short_held", 64'(m_short), 64'(1));
        chk("remainder_held", 64'(m_rem), 64'(3));
        refill = 1'b1;
        @(negedge clk);
        refill = 1'b0;
        exp_coins = '{6'b000001, 6'b000001, 6'b000001};
        txn(1'b0, 16'd3, 1'b0, 1'b0, 16'd0, 1'b0);

        // INIT_COUNT=2 instance: 300 runs out of stock and leaves 18 unpaid.
        exp_coins = '{6'b010000, 6'b010000, 6'b001000, 6'b001000, 6'b000100,
                      6'b000100, 6'b000010, 6'b000010, 6'b000001, 6'b000001};
        txn(1'b1, 16'd300, 1'b0, 1'b1, 16'd18, 1'b0);
        // Refill together with start restocks the 1c coins before selection.
        exp_coins = '{6'b000001};
        txn(1'b1, 16'd1, 1'b1, 1'b0, 16'd0, 1'b0);

        // Reset while the 100c solenoid is firing.
        exp_coins = '{6'b010000};
        @(negedge clk);
        sel = 1'b0;
        sbq.push_back('{is_done: 1'b0, coin: 6'b010000, shrt: 1'b0, rem: '0, dcyc: 0});
        exp_coins.delete();
        start  = 1'b1;
        amount = 16'd130;
        @(negedge clk);
        start  = 1'b0;
        wait_eject(4);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_eject", 64'(bus_a.O_COIN_EJECT), 64'(0));
        chk("rst_mid_busy", 64'(bus_a.O_BUSY), 64'(0));
        chk("rst_mid_done", 64'(bus_a.O_DONE), 64'(0));
        chk("rst_mid_inv_100", 64'(u_dut.inv[4]), 64'(20));
        chk("rst_mid_inv_1", 64'(u_dut.inv[0]), 64'(20));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("post_rst_busy", 64'(bus_a.O_BUSY), 64'(0));
        chk("scoreboard_empty", 64'(sbq.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
